// File: rtl/gpu_bus_arbiter.sv
// Round-robin arbiter that serialises whole 32-bit instructions onto the 8-bit GPU command bus.
// Optional macro BLANK_SYNC_EN: new instructions may only start while i_vblank is high.
module gpu_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [32*NUM_REQ-1:0]   i_req_instr,
  output logic [NUM_REQ-1:0]      o_req_accept,
  output logic [NUM_REQ-1:0]      o_req_done,
  output logic [NUM_REQ-1:0]      o_req_err,
  output logic                    o_we,
  output logic                    o_en,
  output logic [7:0]              o_data,
  input  logic                    i_ack,
  input  logic                    i_busy,
  input  logic                    i_vblank,
  output logic                    o_idle
);

  localparam int unsigned IW      = $clog2(NUM_REQ);
  localparam logic [7:0]  TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic [31:0]   instr_q;
  logic [1:0]    idx;
  logic [7:0]    wait_cnt;
  logic [7:0]    cur_byte;
  logic          found;
  logic          gate_open;
  logic          start;
  logic          timeout_hit;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (32'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

`ifdef BLANK_SYNC_EN
  assign gate_open = i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = i_vblank;
  assign gate_open     = 1'b1;
`endif

  // Scan from ptr upwards, wrapping, and take the first valid requester.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  assign start       = (state == IDLE) && found && !i_busy && gate_open;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_LAST) && !i_ack;
  assign o_idle      = (state == IDLE) && !(|i_req_valid);

  always_comb begin
    cur_byte = '0;
    unique case (idx)
      2'd0: cur_byte = instr_q[31:24];
      2'd1: cur_byte = instr_q[23:16];
      2'd2: cur_byte = instr_q[15:8];
      2'd3: cur_byte = instr_q[7:0];
      default: cur_byte = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_req_accept = '0;
    o_req_done   = '0;
    o_req_err    = '0;
    o_en         = 1'b0;
    o_we         = 1'b0;
    o_data       = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          o_req_accept[pick] = 1'b1;
          state_nxt          = SEND;
        end
      end
      SEND: begin
        o_en   = 1'b1;
        o_we   = 1'b1;
        o_data = cur_byte;
        if (i_ack) begin
          state_nxt = GAP;
        end else if (timeout_hit) begin
          o_req_err[cur] = 1'b1;
          state_nxt      = IDLE;
        end
      end
      GAP: begin
        if (idx == 2'd3) begin
          o_req_done[cur] = 1'b1;
          state_nxt       = IDLE;
        end else begin
          state_nxt = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer moves only when an instruction finishes or aborts, never on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      cur      <= '0;
      instr_q  <= '0;
      idx      <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur      <= pick;
            instr_q  <= i_req_instr[32*pick +: 32];
            idx      <= '0;
            wait_cnt <= '0;
          end
        end
        SEND: begin
          if (i_ack) begin
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            ptr      <= wrap_inc(cur);
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GAP: begin
          if (idx == 2'd3) ptr <= wrap_inc(cur);
          else             idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// Bench for gpu_bus_arbiter: vector table, directed corner sequences and a randomized run
// against a transaction-level model (expected byte queue plus round-robin pointer).
module tb_gpu_bus_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   valid;
  logic [32*NR-1:0] instr;
  logic [NR-1:0]   accept, done, err;
  logic            we, en, ack, busy, vblank, idle;
  logic [7:0]      data;

  int checks = 0;
  int errors = 0;

  gpu_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid), .i_req_instr(instr),
    .o_req_accept(accept), .o_req_done(done), .o_req_err(err),
    .o_we(we), .o_en(en), .o_data(data),
    .i_ack(ack), .i_busy(busy), .i_vblank(vblank),
    .o_idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic       b;
    logic       a;
    logic [1:0] acc;
    logic       en;
    logic [7:0] d;
    logic [1:0] dn;
    logic       idl;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [1:0] v, logic b, logic a, logic [1:0] acc,
                              logic e, logic [7:0] d, logic [1:0] dn, logic idl);
    vec_t r;
    r.v = v; r.b = b; r.a = a; r.acc = acc; r.en = e; r.d = d; r.dn = dn; r.idl = idl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] e_acc, input logic e_en,
                          input logic [7:0] e_d, input logic [1:0] e_dn,
                          input logic [1:0] e_err, input logic e_idl);
    chk({tag, ".accept"}, 32'(accept), 32'(e_acc));
    chk({tag, ".en"},     32'(en),     32'(e_en));
    chk({tag, ".we"},     32'(we),     32'(e_en));
    chk({tag, ".data"},   32'(data),   32'(e_d));
    chk({tag, ".done"},   32'(done),   32'(e_dn));
    chk({tag, ".err"},    32'(err),    32'(e_err));
    chk({tag, ".idle"},   32'(idle),   32'(e_idl));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset (asynchronously, wherever the DUT is), check released bus, release after two edges.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; valid = '0; instr = '0; ack = 1'b0; busy = 1'b0; vblank = 1'b1;
    #1;
    chk_outs(tag, 2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Randomized-run model state
  bit          inflight;
  bit          prev_ack_en;
  bit          found_w;
  int          owner, rr, w, ndone, gwait, gtarget;
  logic [7:0]  exp_q[$];
  logic [NR-1:0] exp_acc, exp_done, acc_last;
  logic        exp_en, exp_idle, gate;
  logic [7:0]  exp_d;
  logic [31:0] wi;

  initial begin
    // Table: instructions 0xA1B2C3D4 (req0) and 0x11223344 (req1), vblank held high.
    tbl[0]  = mk(2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 1);
    tbl[1]  = mk(2'b01, 1, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[2]  = mk(2'b01, 0, 1, 2'b01, 0, 8'h00, 2'b00, 0);
    tbl[3]  = mk(2'b00, 0, 1, 2'b00, 1, 8'hA1, 2'b00, 0);
    tbl[4]  = mk(2'b00, 0, 1, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[5]  = mk(2'b00, 0, 1, 2'b00, 1, 8'hB2, 2'b00, 0);
    tbl[6]  = mk(2'b00, 1, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[7]  = mk(2'b00, 1, 1, 2'b00, 1, 8'hC3, 2'b00, 0);
    tbl[8]  = mk(2'b00, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[9]  = mk(2'b00, 0, 1, 2'b00, 1, 8'hD4, 2'b00, 0);
    tbl[10] = mk(2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b01, 0);
    tbl[11] = mk(2'b11, 0, 0, 2'b10, 0, 8'h00, 2'b00, 0);
    tbl[12] = mk(2'b11, 0, 0, 2'b00, 1, 8'h11, 2'b00, 0);
    tbl[13] = mk(2'b11, 0, 1, 2'b00, 1, 8'h11, 2'b00, 0);
    tbl[14] = mk(2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[15] = mk(2'b11, 0, 1, 2'b00, 1, 8'h22, 2'b00, 0);
    tbl[16] = mk(2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[17] = mk(2'b11, 0, 1, 2'b00, 1, 8'h33, 2'b00, 0);
    tbl[18] = mk(2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0);
    tbl[19] = mk(2'b11, 0, 1, 2'b00, 1, 8'h44, 2'b00, 0);
    tbl[20] = mk(2'b11, 0, 0, 2'b00, 0, 8'h00, 2'b10, 0);
    tbl[21] = mk(2'b11, 0, 0, 2'b01, 0, 8'h00, 2'b00, 0);

    do_reset("reset0");
    instr = {32'h11223344, 32'hA1B2C3D4};
    for (int i = 0; i < 22; i++) begin
      valid = tbl[i].v; busy = tbl[i].b; ack = tbl[i].a;
      #3;
      chk_outs($sformatf("vec%0d", i), tbl[i].acc, tbl[i].en, tbl[i].d, tbl[i].dn, 2'b00, tbl[i].idl);
      next_cycle();
    end

    // Ack timeout: 4 strobe cycles, err on the last, then the other requester wins.
    do_reset("reset_to");
    instr = {32'h01020304, 32'hDEADBEEF};
    valid = 2'b11; ack = 1'b0;
    #3; chk_outs("to_acc", 2'b01, 0, 8'h00, 2'b00, 2'b00, 0);
    next_cycle();
    valid = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      #3; chk_outs($sformatf("to_wait%0d", k), 2'b00, 1, 8'hDE, 2'b00, (k == 4) ? 2'b01 : 2'b00, 0);
      next_cycle();
    end
    #3; chk_outs("to_next_acc", 2'b10, 0, 8'h00, 2'b00, 2'b00, 0);
    next_cycle();
    #3; chk_outs("to_next_byte", 2'b00, 1, 8'h01, 2'b00, 2'b00, 0);

    // Async reset during the second byte, after ptr has moved to 1.
    do_reset("reset_mid");
    instr = {32'h55667788, 32'hA1B2C3D4};
    valid = 2'b01; ack = 1'b1;
    #3; chk("rst_seq.acc0", 32'(accept), 32'h1);
    next_cycle();
    valid = 2'b00;
    repeat (7) next_cycle();
    #3; chk("rst_seq.done0", 32'(done), 32'h1);
    next_cycle();
    valid = 2'b11;
    #3; chk("rst_seq.acc1", 32'(accept), 32'h2);
    next_cycle();
    valid = 2'b00;
    #3; chk("rst_seq.byte0", 32'(data), 32'h55);
    next_cycle();
    next_cycle();
    #1; chk("rst_seq.byte1", 32'({en, data}), 32'h166);
    rst_n = 1'b0;
    #1; chk_outs("rst_async", 2'b00, 0, 8'h00, 2'b00, 2'b00, 1);
    next_cycle();
    chk_outs("rst_hold", 2'b00, 0, 8'h00, 2'b00, 2'b00, 1);
    rst_n = 1'b1; valid = 2'b11; ack = 1'b0;
    #3; chk("rst_ptr_zero.acc", 32'(accept), 32'h1);

`ifdef BLANK_SYNC_EN
    do_reset("reset_vb");
    instr = {32'h0, 32'hCAFEF00D};
    vblank = 1'b0; valid = 2'b01; ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3; chk_outs($sformatf("vb_closed%0d", k), 2'b00, 0, 8'h00, 2'b00, 2'b00, 0);
      next_cycle();
    end
    vblank = 1'b1;
    #3; chk("vb_open.acc", 32'(accept), 32'h1);
    next_cycle();
    vblank = 1'b0; valid = 2'b00;
    for (int b = 0; b < 4; b++) begin
      wi = 32'hCAFEF00D;
      #3; chk($sformatf("vb_byte%0d", b), 32'({en, data}), 32'({1'b1, wi[31-8*b -: 8]}));
      next_cycle();
      #3; chk($sformatf("vb_gap%0d", b), 32'({en, done}), (b == 3) ? 32'h1 : 32'h0);
      next_cycle();
    end
`else
    do_reset("reset_vb");
    instr = {32'h0, 32'hCAFEF00D};
    vblank = 1'b0; valid = 2'b01; ack = 1'b1;
    #3; chk("vb_ignored.acc", 32'(accept), 32'h1);
    next_cycle();
    valid = 2'b00;
    repeat (8) next_cycle();
`endif

    // Randomized run against the transaction-level model.
    do_reset("reset_rand");
    inflight = 0; prev_ack_en = 0; rr = 0; ndone = 0; owner = 0;
    gwait = 0; gtarget = 0; acc_last = '0; exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NR; k++) begin
        if (acc_last[k]) begin
          valid[k] = 1'($urandom % 2);
          instr[32*k +: 32] = $urandom;
        end else if (!valid[k]) begin
          if ($urandom % 3 == 0) begin
            valid[k] = 1'b1;
            instr[32*k +: 32] = $urandom;
          end
        end else if ($urandom % 16 == 0) begin
          valid[k] = 1'b0;
        end
      end
      busy   = ($urandom % 4 == 0);
      vblank = 1'($urandom % 2);
      if (en) ack = (gwait >= gtarget);
      else    ack = 1'($urandom % 2);
      #3;
`ifdef BLANK_SYNC_EN
      gate = vblank;
`else
      gate = 1'b1;
`endif
      exp_acc = '0;
      found_w = 0;
      w = 0;
      if (!inflight && (valid != 0) && !busy && gate) begin
        for (int i = 0; i < NR; i++) begin
          if (!found_w && valid[(rr + i) % NR]) begin
            w = (rr + i) % NR;
            found_w = 1;
          end
        end
        exp_acc[w] = 1'b1;
      end
      exp_done = '0;
      if (inflight && prev_ack_en && exp_q.size() == 0) exp_done[owner] = 1'b1;
      exp_en   = inflight && !prev_ack_en;
      exp_idle = !inflight && (valid == 0);
      exp_d    = (exp_en && exp_q.size() != 0) ? exp_q[0] : 8'h00;
      chk_outs($sformatf("rand%0d", cyc), exp_acc, exp_en, exp_d, exp_done, 2'b00, exp_idle);

      prev_ack_en = exp_en && ack;
      if (exp_en && ack && exp_q.size() != 0) void'(exp_q.pop_front());
      if (exp_done != 0) begin
        inflight = 0;
        rr = (owner + 1) % NR;
        ndone++;
      end
      if (exp_acc != 0) begin
        inflight = 1;
        owner = w;
        wi = instr[32*w +: 32];
        for (int b = 0; b < 4; b++) exp_q.push_back(wi[31-8*b -: 8]);
      end
      acc_last = exp_acc;
      if (en) begin
        if (ack) begin
          gwait = 0;
          gtarget = $urandom % 3;
        end else begin
          gwait++;
        end
      end
      next_cycle();
    end
    chk("rand_progress", 32'(ndone >= 50), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
